// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the ccff chain loader.
// Provides the loader FSM state enum and the word-count / remainder math.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        PUSH,
        DONE
    } state_e;

    // Number of config words needed to cover the chain.
    function automatic int nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits carried by the last word (1..word_w).
    function automatic int rem(input int chain_len, input int word_w);
        return chain_len - (nwords(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Word-wide PISO driving ccff_head plus SIPO collecting ccff_tail.
// Ports: clk_i/rst_i, load_i (data_i, len_i bits), shift_i, tail_i,
//        head_o (current serial bit), rb_o (collected readback word).
module ccff_word_shifter #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              tail_i,
    output logic              head_o,
    output logic [WORD_W-1:0] rb_o
);

    logic [WORD_W-1:0] piso_q, piso_d;
    logic [WORD_W-1:0] sipo_q, sipo_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            piso_q <= '0;
            sipo_q <= '0;
        end else begin
            piso_q <= piso_d;
            sipo_q <= sipo_d;
        end
    end

    // A short word is left-aligned so its top valid bit leaves first;
    // the readback side is cleared so unused upper bits read as 0.
    always_comb begin
        piso_d = piso_q;
        sipo_d = sipo_q;
        if (load_i) begin
            piso_d = data_i << (WORD_W - int'(len_i));
            sipo_d = '0;
        end else if (shift_i) begin
            piso_d = piso_q << 1;
            sipo_d = (sipo_q << 1) | WORD_W'(tail_i);
        end
    end

    assign head_o = piso_q[WORD_W-1];
    assign rb_o   = sipo_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads one ccff chain segment from parallel config words, MSB-first,
// and returns the displaced chain bits as readback words.
// Ports: prog_clk/prog_reset, start/abort control, cfg_* word input,
//        ccff_head/ccff_tail/shift_en chain side, rb_* readback output,
//        busy/done/aborted status.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 2,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int NWORDS    = nwords(CHAIN_LEN, WORD_W);
    localparam int REM       = rem(CHAIN_LEN, WORD_W);
    localparam int LAST_BASE = (NWORDS - 1) * WORD_W;
    localparam int BW        = $clog2(WORD_W + 1);
    localparam int TW        = $clog2(CHAIN_LEN + 1);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] total_cnt_q, total_cnt_d;
    logic [BW-1:0] len_q, len_d;
    logic          shift_en_q, shift_en_d;
    logic          aborted_q, aborted_d;

    logic          do_abort;
    logic          load_w;
    logic          shift_w;
    logic          word_end;
    logic          last_word;
    logic          total_full;

    assign do_abort   = abort && (state_q != IDLE);
    assign load_w     = (state_q == FETCH) && cfg_valid && cfg_ready;
    assign shift_w    = (state_q == SHIFT);
    assign word_end   = shift_w && ((bit_cnt_q + BW'(1)) == len_q);
    assign last_word  = int'(total_cnt_q) >= LAST_BASE;
    assign total_full = (total_cnt_q == TW'(CHAIN_LEN));

    // State register
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (load_w) state_d = SHIFT;
            SHIFT:   if (word_end) state_d = PUSH;
            PUSH:    if (rb_ready) state_d = total_full ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (do_abort) state_d = IDLE;
    end

    // Output decode
    always_comb begin
        rb_valid  = (state_q == PUSH);
        cfg_ready = (state_q == FETCH) && !rb_valid;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    // Counters and registered chain-side strobes
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        total_cnt_d = total_cnt_q;
        len_d       = len_q;
        if ((state_q == IDLE) && start) begin
            total_cnt_d = '0;
        end
        if (load_w) begin
            bit_cnt_d = '0;
            len_d     = last_word ? BW'(REM) : BW'(WORD_W);
        end
        if (shift_w) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (!total_full) total_cnt_d = total_cnt_q + TW'(1);
        end
        // shift_en registered alongside the PISO so head and enable align
        shift_en_d = (state_d == SHIFT);
        aborted_d  = do_abort;
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            bit_cnt_q   <= '0;
            total_cnt_q <= '0;
            len_q       <= '0;
            shift_en_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            total_cnt_q <= total_cnt_d;
            len_q       <= len_d;
            shift_en_q  <= shift_en_d;
            aborted_q   <= aborted_d;
        end
    end

    assign shift_en = shift_en_q;
    assign aborted  = aborted_q;

    ccff_word_shifter #(
        .WORD_W (WORD_W),
        .LEN_W  (BW)
    ) u_shifter (
        .clk_i   (prog_clk),
        .rst_i   (prog_reset),
        .load_i  (load_w),
        .shift_i (shift_w),
        .len_i   (len_d),
        .data_i  (cfg_data),
        .tail_i  (ccff_tail),
        .head_o  (ccff_head),
        .rb_o    (rb_data)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 2-bit and a 20-bit chain,
// each modelled as a shift register clocked on prog_clk && shift_en.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: CHAIN_LEN=2 ----------------
    logic       a_start, a_abort, a_cfg_valid, a_cfg_ready;
    logic [7:0] a_cfg_data, a_rb_data;
    logic       a_head, a_tail, a_shift_en, a_rb_valid, a_rb_ready;
    logic       a_busy, a_done, a_aborted;
    logic [1:0] a_chain, a_pre_val;
    logic       a_pre_en;
    int         a_shifts = 0;
    int         a_dones  = 0;
    int         a_rbn    = 0;
    logic [7:0] a_rb_log [16];

    assign a_tail = a_chain[1];

    always @(posedge clk) begin
        if (a_pre_en) a_chain <= a_pre_val;
        else if (a_shift_en) a_chain <= {a_chain[0], a_head};
        if (a_shift_en) a_shifts <= a_shifts + 1;
        if (a_done) a_dones <= a_dones + 1;
        if (a_rb_valid && a_rb_ready) begin
            a_rb_log[a_rbn % 16] <= a_rb_data;
            a_rbn <= a_rbn + 1;
        end
    end

    ccff_chain_loader #(.CHAIN_LEN(2), .WORD_W(8)) u_a (
        .prog_clk   (clk),
        .prog_reset (rst),
        .start      (a_start),
        .abort      (a_abort),
        .cfg_data   (a_cfg_data),
        .cfg_valid  (a_cfg_valid),
        .cfg_ready  (a_cfg_ready),
        .ccff_head  (a_head),
        .ccff_tail  (a_tail),
        .shift_en   (a_shift_en),
        .rb_data    (a_rb_data),
        .rb_valid   (a_rb_valid),
        .rb_ready   (a_rb_ready),
        .busy       (a_busy),
        .done       (a_done),
        .aborted    (a_aborted)
    );

    // ---------------- instance B: CHAIN_LEN=20 ----------------
    logic        b_start, b_abort, b_cfg_valid, b_cfg_ready;
    logic [7:0]  b_cfg_data, b_rb_data;
    logic        b_head, b_tail, b_shift_en, b_rb_valid, b_rb_ready;
    logic        b_busy, b_done, b_aborted;
    logic [19:0] b_chain, b_pre_val;
    logic        b_pre_en;
    int          b_shifts = 0;
    int          b_dones  = 0;
    int          b_rbn    = 0;
    int          b_widx   = 0;
    logic [7:0]  b_rb_log [64];
    logic [7:0]  b_words  [64];

    assign b_tail     = b_chain[19];
    assign b_cfg_data = b_words[b_widx % 64];

    always @(posedge clk) begin
        if (b_pre_en) b_chain <= b_pre_val;
        else if (b_shift_en) b_chain <= {b_chain[18:0], b_head};
        if (b_shift_en) b_shifts <= b_shifts + 1;
        if (b_done) b_dones <= b_dones + 1;
        if (b_rb_valid && b_rb_ready) begin
            b_rb_log[b_rbn % 64] <= b_rb_data;
            b_rbn <= b_rbn + 1;
        end
        if (b_cfg_valid && b_cfg_ready) b_widx <= b_widx + 1;
    end

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_b (
        .prog_clk   (clk),
        .prog_reset (rst),
        .start      (b_start),
        .abort      (b_abort),
        .cfg_data   (b_cfg_data),
        .cfg_valid  (b_cfg_valid),
        .cfg_ready  (b_cfg_ready),
        .ccff_head  (b_head),
        .ccff_tail  (b_tail),
        .shift_en   (b_shift_en),
        .rb_data    (b_rb_data),
        .rb_valid   (b_rb_valid),
        .rb_ready   (b_rb_ready),
        .busy       (b_busy),
        .done       (b_done),
        .aborted    (b_aborted)
    );

    // ---------------- helpers ----------------
    int s_sh, s_rb, s_dn, s_wi, bad;

    task automatic b_set_words(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2);
        b_words[b_widx % 64]       = w0;
        b_words[(b_widx + 1) % 64] = w1;
        b_words[(b_widx + 2) % 64] = w2;
    endtask

    task automatic b_snap();
        s_sh = b_shifts;
        s_rb = b_rbn;
        s_dn = b_dones;
        s_wi = b_widx;
    endtask

    task automatic b_go();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic b_wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_done) break;
        end
        check(tag, b_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic b_wait_shift(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_shift_en) break;
        end
        check(tag, b_shift_en, 1'b1);
    endtask

    task automatic b_check_rb3(input string tag, input logic [7:0] w0,
                               input logic [7:0] w1, input logic [7:0] w2);
        check({tag, "_rbn"}, b_rbn - s_rb, 3);
        check({tag, "_rb0"}, b_rb_log[s_rb % 64], w0);
        check({tag, "_rb1"}, b_rb_log[(s_rb + 1) % 64], w1);
        check({tag, "_rb2"}, b_rb_log[(s_rb + 2) % 64], w2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst         = 1'b1;
        a_start     = 1'b0;
        a_abort     = 1'b0;
        a_cfg_valid = 1'b0;
        a_cfg_data  = 8'h00;
        a_rb_ready  = 1'b1;
        a_pre_en    = 1'b1;
        a_pre_val   = 2'b01;  // DFF_0=1, DFF_1=0
        b_start     = 1'b0;
        b_abort     = 1'b0;
        b_cfg_valid = 1'b0;
        b_rb_ready  = 1'b1;
        b_pre_en    = 1'b1;
        b_pre_val   = 20'h0;
        for (int i = 0; i < 64; i++) b_words[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_outs_b",
              {b_cfg_ready, b_head, b_shift_en, b_rb_valid,
               b_busy, b_done, b_aborted}, 7'd0);
        check("rst_rb_data_b", b_rb_data, 8'h00);
        check("rst_outs_a",
              {a_cfg_ready, a_head, a_shift_en, a_rb_valid,
               a_busy, a_done, a_aborted}, 7'd0);
        rst      = 1'b0;
        a_pre_en = 1'b0;
        b_pre_en = 1'b0;
        @(negedge clk);

        // 1: two-bit chain, word 03, chain preset DFF_0=1 DFF_1=0
        check("t1_chain_pre", a_chain, 2'b01);
        a_cfg_data  = 8'h03;
        a_cfg_valid = 1'b1;
        a_start     = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("t1_fetch_ready", a_cfg_ready, 1'b1);
        check("t1_fetch_noshift", a_shift_en, 1'b0);
        @(negedge clk);
        check("t1_first_shift", a_shift_en, 1'b1);
        check("t1_first_head", a_head, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (a_done) break;
            @(negedge clk);
        end
        check("t1_done", a_done, 1'b1);
        @(negedge clk);
        a_cfg_valid = 1'b0;
        check("t1_shifts", a_shifts, 2);
        check("t1_chain", a_chain, 2'b11);
        check("t1_rbn", a_rbn, 1);
        check("t1_rb", a_rb_log[0], 8'h01);
        check("t1_dones", a_dones, 1);
        check("t1_idle", a_busy, 1'b0);

        // 2: 20-bit chain, A5 3C 0F over a cleared chain
        b_snap();
        b_set_words(8'hA5, 8'h3C, 8'h0F);
        b_cfg_valid = 1'b1;
        b_go();
        b_wait_done("t2_done");
        check("t2_shifts", b_shifts - s_sh, 20);
        check("t2_words", b_widx - s_wi, 3);
        b_check_rb3("t2", 8'h00, 8'h00, 8'h00);
        check("t2_chain", b_chain, 20'hA53CF);

        // 3: readback stall after the first word, then resume
        b_snap();
        b_set_words(8'h12, 8'h34, 8'h56);
        b_rb_ready = 1'b0;
        b_go();
        for (int i = 0; i < 50; i++) begin
            if (b_rb_valid) break;
            @(negedge clk);
        end
        check("t3_rb_valid", b_rb_valid, 1'b1);
        check("t3_rb_hold", b_rb_data, 8'hA5);
        bad = 0;
        s_sh = b_shifts;
        repeat (5) begin
            @(negedge clk);
            if (b_cfg_ready || b_shift_en || !b_rb_valid) bad++;
        end
        check("t3_stall", bad, 0);
        check("t3_stall_shifts", b_shifts - s_sh, 0);
        s_sh = s_sh - 8;
        b_rb_ready = 1'b1;
        b_wait_done("t3_done");
        check("t3_shifts", b_shifts - s_sh, 20);
        b_check_rb3("t3", 8'hA5, 8'h3C, 8'h0F);
        check("t3_chain", b_chain, 20'h12346);

        // 4: abort while shifting bit 3 of C5
        b_snap();
        b_set_words(8'hC5, 8'h00, 8'h00);
        b_go();
        b_wait_shift("t4_shifting");
        repeat (3) @(negedge clk);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        check("t4_shift_en", b_shift_en, 1'b0);
        check("t4_aborted", b_aborted, 1'b1);
        check("t4_busy", b_busy, 1'b0);
        @(negedge clk);
        check("t4_aborted_pulse", b_aborted, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_no_done", b_dones - s_dn, 0);
        check("t4_shifts", b_shifts - s_sh, 4);
        check("t4_no_rb", b_rbn - s_rb, 0);
        check("t4_chain", b_chain, 20'h2346C);

        // 4b/6: fresh load after abort, with a stray start mid-load
        b_snap();
        b_set_words(8'h11, 8'h22, 8'h33);
        b_go();
        b_wait_shift("t6_shifting");
        repeat (2) @(negedge clk);
        b_go();
        b_wait_done("t6_done");
        check("t6_shifts", b_shifts - s_sh, 20);
        check("t6_dones", b_dones - s_dn, 1);
        b_check_rb3("t6", 8'h23, 8'h46, 8'h0C);
        check("t6_chain", b_chain, 20'h11223);

        // 6: cfg_valid held while idle
        b_snap();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_cfg_ready || b_busy || b_shift_en) bad++;
        end
        check("t6_idle_quiet", bad, 0);
        check("t6_idle_words", b_widx - s_wi, 0);
        check("t6_idle_chain", b_chain, 20'h11223);

        // 5: reset in the middle of a load
        b_set_words(8'hAA, 8'hBB, 8'hCC);
        b_go();
        b_wait_shift("t5_shifting");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_shift_en", b_shift_en, 1'b0);
        check("t5_outs",
              {b_cfg_ready, b_head, b_rb_valid, b_busy,
               b_done, b_aborted}, 6'd0);
        check("t5_rb_data", b_rb_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        b_snap();
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_cfg_ready || b_busy || b_shift_en) bad++;
        end
        check("t5_idle_quiet", bad, 0);
        check("t5_words", b_widx - s_wi, 0);
        check("t5_shifts", b_shifts - s_sh, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
